matmul_sequencer: RTL
=====================

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 Parameters SHALL be: DWIDTH 16 (element bits); AWIDTH 7 (BRAM address bits); MAT_MUL_SIZE 8 (elements per row); ROWS 8 (rows per matrix, 1..2^AWIDTH); WR_LAT 2 (addr_pi-to-RAM-address delay on the write path); RD_LAT 3 (addr_pi-to-data_from_out_mat delay).
REQ-002 Ports: clk in 1, sole clock; reset_n in 1, reset; asynchronous, active-low.
REQ-003 Host side: in_valid in 1; in_ready out 1; in_data in MAT_MUL_SIZE*DWIDTH (one row; A rows first, then B rows); go in 1 (start request); busy out 1.
REQ-004 Host side: out_valid out 1; out_ready in 1; out_data out MAT_MUL_SIZE*DWIDTH (one C row); done out 1 (single-cycle pulse after the last C row is accepted).
REQ-005 Datapath side: enable_writing_to_mem out 1; enable_reading_from_mem out 1; addr_pi out AWIDTH; data_pi out MAT_MUL_SIZE*DWIDTH; we_a, we_b, we_c out 1 each; start_mat_mul out 1; done_mat_mul in 1; data_from_out_mat in MAT_MUL_SIZE*DWIDTH.

Function
REQ-006 FSM states SHALL be IDLE, LOAD_A, LOAD_B, WR_DRAIN, COMPUTE, RD_C, FINISH.
REQ-007 IDLE -> LOAD_A when go=1; go SHALL be ignored in every other state.
REQ-008 LOAD_A/LOAD_B: in_ready=1; each in_valid&in_ready handshake SHALL drive addr_pi=row index (0..ROWS-1) with enable_writing_to_mem=1 in that cycle.
REQ-009 data_pi and we_a (LOAD_A) or we_b (LOAD_B) SHALL be asserted exactly WR_LAT cycles after the matching addr_pi, via an internal delay pipeline; we_a and we_b SHALL never be high together.
REQ-010 LOAD_A -> LOAD_B after handshake of row ROWS-1; LOAD_B -> WR_DRAIN likewise; in_ready=0 in all other states.
REQ-011 WR_DRAIN SHALL last WR_LAT cycles, keeping enable_writing_to_mem=1 until the final write completes, then go to COMPUTE.
REQ-012 COMPUTE: start_mat_mul=1 and we_c=1 continuously; on done_mat_mul=1, both drop the next cycle and the FSM goes to RD_C.
REQ-013 RD_C: enable_reading_from_mem=1; issue addr_pi=0..ROWS-1 one per cycle, only while outstanding reads plus FIFO occupancy < RD_LAT+1.
REQ-014 data_from_out_mat SHALL be captured RD_LAT cycles after each issue into an output FIFO of depth RD_LAT+1; out_valid = FIFO not empty; pop on out_valid&out_ready; out_data stable while out_valid&!out_ready.
REQ-015 RD_C -> FINISH after the last issue; FINISH -> IDLE with done=1 for one cycle when the FIFO is empty and no reads are outstanding.
REQ-016 busy=1 in every state except IDLE.
REQ-017 in_valid while in_ready=0 SHALL have no effect; in_data is not buffered.
REQ-018 done_mat_mul outside COMPUTE SHALL be ignored.

Reset
REQ-019 reset_n=0 SHALL asynchronously force IDLE, clear row counter, delay pipeline, read-credit counter and FIFO; all outputs 0 (addr_pi, data_pi, out_data 0).
REQ-020 Reset mid-operation SHALL abort with no further writes; no done pulse.

Configuration
REQ-021 With SEQ_PERF_CNT_EN defined: extra output compute_cycles out 16, cleared on go, incremented each COMPUTE cycle, saturating at 16'hFFFF, held until next go; without it the port and counter SHALL be absent.

Structure
REQ-022 Package matmul_seq_pkg SHALL hold the state enum, DWIDTH/AWIDTH/MAT_MUL_SIZE defaults and the row-width constant.
REQ-023 Output buffering SHALL be one sub-module, matmul_seq_out_fifo (synchronous, parameterised width/depth, full/empty flags).

Verification
REQ-024 go, 16 back-to-back rows (A rows 0x01.., B rows 0x11..) -> addr_pi 0..7 twice; we_a then we_b each high 8 cycles, 2 cycles after addr; in_ready drops after row 16.
REQ-025 in_valid toggling every other cycle during load -> exactly 16 writes, addresses contiguous, no duplicates.
REQ-026 done_mat_mul pulsed 40 cycles after start_mat_mul rises -> start_mat_mul/we_c high exactly 40 cycles, RD_C entered next cycle.
REQ-027 out_ready held 0 for 20 cycles in RD_C -> at most 4 reads outstanding+buffered, no row lost; 8 rows emitted in address order once ready, then single done pulse.
REQ-028 reset_n low during LOAD_B row 3 -> outputs 0 immediately; a fresh go then completes normally.
REQ-029 SEQ_PERF_CNT_EN defined, 40-cycle compute -> compute_cycles=40; 70000-cycle compute -> 0xFFFF.

Source files
------------

// File: rtl/matmul_seq_pkg.sv
// Shared FSM state codes and default geometry for the matmul sequencer.
// Default row width is MAT_MUL_SIZE elements of DWIDTH bits.
package matmul_seq_pkg;
  localparam int DEF_DWIDTH       = 16;
  localparam int DEF_AWIDTH       = 7;
  localparam int DEF_MAT_MUL_SIZE = 8;
  localparam int DEF_ROW_W        = DEF_MAT_MUL_SIZE * DEF_DWIDTH;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_LOAD_A   = 3'd1;
  localparam state_t ST_LOAD_B   = 3'd2;
  localparam state_t ST_WR_DRAIN = 3'd3;
  localparam state_t ST_COMPUTE  = 3'd4;
  localparam state_t ST_RD_C     = 3'd5;
  localparam state_t ST_FINISH   = 3'd6;
endpackage

// File: rtl/matmul_seq_out_fifo.sv
// Synchronous FIFO for C rows; head is visible on pop_data while not empty.
// Pushes when full and pops when empty are dropped.
module matmul_seq_out_fifo
  import matmul_seq_pkg::*;
#(
  parameter int WIDTH = DEF_ROW_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               count;
  logic                        do_push, do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/matmul_sequencer.sv
// Sequences A/B row loads into the matmul BRAMs, runs the multiply, streams C rows out.
// Optional SEQ_PERF_CNT_EN adds a saturating compute_cycles counter output.
module matmul_sequencer
  import matmul_seq_pkg::*;
#(
  parameter int DWIDTH       = DEF_DWIDTH,
  parameter int AWIDTH       = DEF_AWIDTH,
  parameter int MAT_MUL_SIZE = DEF_MAT_MUL_SIZE,
  parameter int ROWS         = 8,
  parameter int WR_LAT       = 2,
  parameter int RD_LAT       = 3
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] in_data,
  input  logic                           go,
  output logic                           busy,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
  output logic                           done,
  output logic                           enable_writing_to_mem,
  output logic                           enable_reading_from_mem,
  output logic [AWIDTH-1:0]              addr_pi,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] data_pi,
  output logic                           we_a,
  output logic                           we_b,
  output logic                           we_c,
  output logic                           start_mat_mul,
  input  logic                           done_mat_mul,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] data_from_out_mat
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [15:0]                    compute_cycles
`endif
);
  localparam int RW  = MAT_MUL_SIZE * DWIDTH;
  localparam int CRW = $clog2(RD_LAT + 2);
  localparam logic [AWIDTH-1:0] LAST_ROW = AWIDTH'(ROWS - 1);

  state_t                     state, state_nx;
  logic [AWIDTH-1:0]          row_cnt;
  logic                       hs, issue, pop, push, fifo_full, fifo_empty;
  logic [WR_LAT-1:0]          wp_vld, wp_b;
  logic [WR_LAT-1:0][RW-1:0]  wp_dat;
  logic [RD_LAT-1:0]          rp_vld;
  logic [CRW-1:0]             credits;

  assign in_ready                = (state == ST_LOAD_A) || (state == ST_LOAD_B);
  assign hs                      = in_valid && in_ready;
  assign enable_writing_to_mem   = in_ready || (state == ST_WR_DRAIN);
  assign enable_reading_from_mem = (state == ST_RD_C);
  // credits = reads in flight + rows sitting in the FIFO; bounded so the FIFO never overflows
  assign issue         = enable_reading_from_mem && !fifo_full && (credits < CRW'(RD_LAT + 1));
  assign addr_pi       = (hs || issue) ? row_cnt : '0;
  assign start_mat_mul = (state == ST_COMPUTE);
  assign we_c          = start_mat_mul;
  assign busy          = (state != ST_IDLE);
  assign data_pi       = wp_dat[WR_LAT-1];
  assign we_a          = wp_vld[WR_LAT-1] && !wp_b[WR_LAT-1];
  assign we_b          = wp_vld[WR_LAT-1] && wp_b[WR_LAT-1];
  assign push          = rp_vld[RD_LAT-1];
  assign out_valid     = !fifo_empty;
  assign pop           = out_valid && out_ready;
  assign done          = (state == ST_FINISH) && (credits == '0);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (go) state_nx = ST_LOAD_A;
      ST_LOAD_A:   if (hs && row_cnt == LAST_ROW) state_nx = ST_LOAD_B;
      ST_LOAD_B:   if (hs && row_cnt == LAST_ROW) state_nx = ST_WR_DRAIN;
      ST_WR_DRAIN: if (row_cnt == AWIDTH'(WR_LAT - 1)) state_nx = ST_COMPUTE;
      ST_COMPUTE:  if (done_mat_mul) state_nx = ST_RD_C;
      ST_RD_C:     if (issue && row_cnt == LAST_ROW) state_nx = ST_FINISH;
      ST_FINISH:   if (credits == '0) state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      row_cnt <= '0;
      wp_vld  <= '0;
      wp_b    <= '0;
      wp_dat  <= '0;
      rp_vld  <= '0;
      credits <= '0;
    end else begin
      state <= state_nx;
      // row_cnt doubles as the drain timer; it restarts on every state change
      if (state_nx != state)
        row_cnt <= '0;
      else if (hs || issue || state == ST_WR_DRAIN)
        row_cnt <= row_cnt + 1'b1;
      wp_vld[0] <= hs;
      wp_b[0]   <= hs && (state == ST_LOAD_B);
      wp_dat[0] <= hs ? in_data : '0;
      for (int i = 1; i < WR_LAT; i++) begin
        wp_vld[i] <= wp_vld[i-1];
        wp_b[i]   <= wp_b[i-1];
        wp_dat[i] <= wp_dat[i-1];
      end
      rp_vld[0] <= issue;
      for (int i = 1; i < RD_LAT; i++)
        rp_vld[i] <= rp_vld[i-1];
      case ({issue, pop})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  matmul_seq_out_fifo #(.WIDTH(RW), .DEPTH(RD_LAT + 1)) u_out_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (data_from_out_mat),
    .pop       (pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      compute_cycles <= '0;
    else if (state == ST_IDLE && go)
      compute_cycles <= '0;
    else if (state == ST_COMPUTE && compute_cycles != 16'hFFFF)
      compute_cycles <= compute_cycles + 1'b1;
  end
`endif
endmodule
